// File: rtl/tx_crc5_serializer.sv
// Token word serializer: pops one word per frame, shifts it out LSB first, then
// appends the inverted USB CRC5 (x^5+x^2+1, init all-ones) MSB first.
module tx_crc5_serializer #(
   parameter int WIDTH = 11
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA_UP,
   input  logic             VALID_UP,
   output logic             READY_UP,
   output logic             BIT_OUT,
   output logic             BIT_VALID,
   input  logic             BIT_READY,
   output logic             BIT_LAST,
   output logic             FRAME_BUSY,
   output logic [4:0]       CRC_VALUE
);

   // The counter also walks the 5 CRC bits, so it needs at least 3 bits even for tiny WIDTH.
   localparam int CW = ($clog2(WIDTH) < 3) ? 3 : $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shreg_reg, shreg_next;
   logic [4:0]       crc_reg, crc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [4:0]       crc_value_reg, crc_value_next;

   logic             fb;
   logic [4:0]       crc_step;
   logic [2:0]       bit_sel;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg     <= IDLE;
         shreg_reg     <= '0;
         crc_reg       <= 5'h1F;
         cnt_reg       <= '0;
         crc_value_reg <= 5'h00;
      end else begin
         state_reg     <= state_next;
         shreg_reg     <= shreg_next;
         crc_reg       <= crc_next;
         cnt_reg       <= cnt_next;
         crc_value_reg <= crc_value_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      shreg_next     = shreg_reg;
      crc_next       = crc_reg;
      cnt_next       = cnt_reg;
      crc_value_next = crc_value_reg;
      READY_UP       = 1'b0;
      BIT_VALID      = 1'b0;
      BIT_OUT        = 1'b0;
      BIT_LAST       = 1'b0;

      fb       = crc_reg[4] ^ shreg_reg[0];
      crc_step = {crc_reg[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      // CRC bits leave MSB first: cnt 0 selects bit 4.
      bit_sel  = 3'd4 - cnt_reg[2:0];

      case (state_reg)
         IDLE: begin
            READY_UP = 1'b1;
            if (VALID_UP) begin
               shreg_next = DATA_UP;
               crc_next   = 5'h1F;
               cnt_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            BIT_VALID = 1'b1;
            BIT_OUT   = shreg_reg[0];
            if (BIT_READY) begin
               crc_next   = crc_step;
               shreg_next = shreg_reg >> 1;
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  state_next     = CRC;
                  cnt_next       = '0;
                  crc_value_next = ~crc_step;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         CRC: begin
            BIT_VALID = 1'b1;
            BIT_OUT   = crc_value_reg[bit_sel];
            BIT_LAST  = (cnt_reg == CW'(4));
            if (BIT_READY) begin
               if (cnt_reg == CW'(4)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign FRAME_BUSY = (state_reg != IDLE);
   assign CRC_VALUE  = crc_value_reg;

endmodule
